// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks:
// controller state encoding, default operand width and counter sizing.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must reach WIDTH without wrapping, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/fullsubtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
// Purely combinational; the serial datapath instantiates exactly one.
module fullsubtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor (A - B, LSB first) with start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-2:0]   res_sr_q, res_sr_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic               d_bit;
    logic               bout_bit;
    logic [WIDTH-1:0]   shifted_res;

    fullsubtractor_cell u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // The new bit enters at the MSB; after WIDTH shifts this is the full result.
    assign shifted_res = {d_bit, res_sr_q};

    always_comb begin
        // NOTE: every next-state variable holds its current value by default so no latch is inferred.
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_sr_d     = res_sr_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        ovf_d        = ovf_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = shifted_res[WIDTH-1:1];
                borrow_d = bout_bit;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    diff_d       = shifted_res;
                    borrow_out_d = bout_bit;
                    state_d      = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d        = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_sr_q     <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_sr_q     <= res_sr_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes A − B one bit per clock, LSB first, with a registered borrow.
- Inverse companion of the combinational full-adder cell; a full-subtractor cell sits in a shift-register datapath.
- Used where area matters more than latency.
- Start/done handshake: a controller launches an operation and collects the result when it completes.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  launch request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result is valid.
- diff  output  WIDTH  result (A − B) mod 2^WIDTH; registered; holds until the next completion.
- borrow_out  output  1  final borrow (1 when A < B unsigned); holds with diff.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; internal shift registers, borrow and bit counter cleared. Applies immediately, including mid-operation; the in-flight operation is discarded and no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge k →
  - load a_sr←a, b_sr←b;
  - borrow←0, cnt←0;
  - state→SHIFT, busy=1 from edge k.
- SHIFT: each edge processes bit x=a_sr[0], y=b_sr[0], br=borrow:
  - d = x^y^br;
  - borrow_next = (~x&y) | (~(x^y)&br);
  - d shifts into the MSB of the result shift register; a_sr and b_sr shift right;
  - cnt increments.
- SHIFT exit: after WIDTH bit edges (edges k+1..k+WIDTH), at edge k+WIDTH:
  - diff←full result, borrow_out←final borrow;
  - done←1, busy←0, state→DONE.
- Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH cycles after start is sampled.
- DONE: lasts exactly one cycle; done=0 at the next edge.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no dead cycle); otherwise →IDLE.
- start while SHIFT: ignored. Operands are not re-captured and the counter is unaffected.
- diff and borrow_out change only at completion edges; they are stable throughout a subsequent operation.
- cnt width: $clog2(WIDTH)+1. Counter does not wrap within an operation.
- Changes to a/b inputs while busy have no effect.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit), registered with diff at completion and reset to 0. ovf = signed two's-complement overflow = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), computed from the captured operand MSBs and the result MSB.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum (IDLE, SHIFT, DONE) and its encoding;
  - default WIDTH constant;
  - counter-width function.
- One natural sub-module: fullsubtractor_cell (combinational: x, y, bin → d, bout). Instantiated once in the datapath so the cell can be unit-tested in isolation.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start 1 cycle → busy 8 cycles; done pulses 8 cycles after start edge; diff=0x02, borrow_out=0.
- a=0x03, b=0x05 → diff=0xFE, borrow_out=1. a=0x00, b=0x00 → diff=0x00, borrow_out=0.
- Back-to-back: hold start high through DONE with a=0xFF, b=0x01 then a=0x10, b=0x20 → diff=0xFE/bo=0, then immediately 0xF0/bo=1, no idle cycle between ops.
- start pulsed and a/b changed mid-SHIFT → ignored; result matches the originally captured operands; exactly one done pulse.
- rst_n asserted at bit 4 of an operation → all outputs 0 immediately; no done. A fresh start after release gives a correct result.
- SERIAL_SUB_OVF_EN: a=0x80, b=0x01 → diff=0x7F, ovf=1, borrow_out=0. a=0x7F, b=0xFF → diff=0x80, ovf=1, borrow_out=1. a=0x05, b=0x03 → ovf=0.
